k_means_sched: RTL and testbench
================================

# k_means_sched

Iteration scheduler for the k-means core. It sits between the APB-side `go` and the classification/centroid-update datapath. On `go` it drives one classification pass over all points, then a centroid update, and repeats until no point changes cluster or the iteration limit is hit. It then writes the final centroids and a status word to the register file and raises `interupt`.

## Interface
- `addrWidth`, 8: point-address and register-number width
- `dataWidth`, 91: centroid / register data width
- `CENT_BASE`, 8'h10: register number of centroid 0
- `STATUS_REG`, 8'h20: register number of the status word

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `go`  in  1  start request, sampled only in IDLE/DONE
- `num_points`  in  addrWidth  point count N (0..255), latched on accepted `go`
- `centroid_cnt`  in  3  k-1 (k = 1..8), latched on accepted `go`
- `max_iter`  in  8  iteration limit M (0 treated as 1), latched on accepted `go`
- `cls_start`  out  1  one-cycle pulse: classify point `cls_point_addr`
- `cls_point_addr`  out  addrWidth  point index, valid with `cls_start`
- `cls_done`  in  1  one-cycle pulse: classification of current point finished
- `cls_changed`  in  1  qualified by `cls_done`: point changed cluster
- `upd_start`  out  1  one-cycle pulse: recompute centroids from accumulators
- `upd_done`  in  1  one-cycle pulse: centroid update finished
- `cen_idx`  out  3  centroid select for readout
- `cen_data`  in  dataWidth  centroid value for `cen_idx`, combinational, same cycle
- `reg_num`  out  addrWidth  register-file write address
- `reg_w_r`  out  1  register-file write strobe
- `reg_write_data`  out  dataWidth  register-file write data
- `busy`  out  1  high from accepted `go` until DONE
- `interupt`  out  1  completion flag, level

## Operation
- FSM states: IDLE, CLS_ISSUE, CLS_WAIT, UPD_ISSUE, UPD_WAIT, WB_CENT, WB_STAT, DONE.
- IDLE/DONE + `go`:
  - latch N, k, M; clear `pt_cnt`, `iter_cnt` and `changed_any`; clear `interupt`.
  - If N=0, go to WB_STAT with `converged`=1.
  - Otherwise go to CLS_ISSUE.
- CLS_ISSUE: `cls_start`=1 and `cls_point_addr`=`pt_cnt` for exactly one cycle, then CLS_WAIT.
- CLS_WAIT:
  - Ignore everything until `cls_done`.
  - On `cls_done`, set `changed_any` |= `cls_changed`.
  - If `pt_cnt` < N-1, increment `pt_cnt` and return to CLS_ISSUE.
  - Otherwise the pass is complete.
- End of pass:
  - If `iter_cnt` > 0 and no change was seen this pass (including the final point), set `converged`=1 and go to WB_CENT.
  - Otherwise go to UPD_ISSUE. The first pass always updates.
- UPD_ISSUE: `upd_start` one cycle, then UPD_WAIT.
- UPD_WAIT on `upd_done`:
  - `iter_cnt`++.
  - If `iter_cnt` reaches M, set `converged`=0 and go to WB_CENT.
  - Otherwise clear `pt_cnt` and `changed_any`, then go to CLS_ISSUE.
- WB_CENT: for i = 0..k-1, one per cycle: `cen_idx`=i, `reg_w_r`=1, `reg_num`=CENT_BASE+i, `reg_write_data`=`cen_data`.
- WB_STAT: one write, `reg_num`=STATUS_REG, data = zero-extended {`converged`, `iter_cnt`[7:0]} (bit 8 = `converged`), then DONE.
- DONE: `interupt`=1 and held until the next accepted `go`.
- `go` in any state other than IDLE/DONE is ignored. Stray `cls_done`/`upd_done` outside their wait states are ignored.
- `iter_cnt` saturates at 255. M ≤ 255, so wrap is unreachable.

## Timing
- Reset: state IDLE. All outputs 0, except `cls_point_addr`, `cen_idx`, `reg_num` and `reg_write_data`, which also reset to 0. All counters are 0.
- `rst` mid-operation aborts immediately. No pending pulse or write survives reset.
- `go` sampled at edge t → `cls_start` high in cycle t+1, `busy` high from t+1.
- Per point: at least 2 cycles (issue + wait). `cls_done` may arrive no earlier than the cycle after `cls_start`.
- End of pass:
  - `cls_done` of the last point at t → `upd_start` at t+1 (not converged), or first WB_CENT write at t+1 (converged).
- Writeback: k consecutive write cycles, then the status write, then DONE.
  - `interupt` rises the cycle after the status write.
- All outputs are registered, except `reg_write_data` in WB_CENT, which passes `cen_data` through combinationally.

## Structure
- Package `k_means_pkg`:
  - state enum `sched_state_t`
  - `CENT_BASE`, `STATUS_REG`, `MAX_K`=8
  - status-word bit positions
- Single module, no sub-module.
- Counters are `pt_cnt` (addrWidth) and `iter_cnt` (8), plus a 3-bit writeback index.

## Test plan
- N=4, k=3, M=10; `cls_changed`=1 in passes 0–1 and 0 in pass 2 → exactly 4 `cls_start` per pass, 2 `upd_start` total, writes to 0x10,0x11,0x12, then 0x20 with data 0x102, then `interupt`=1.
- N=2, k=1, M=3; `cls_changed` always 1 → 3 updates, status data 0x003 (not converged), 1 centroid write.
- N=0, `go` → no `cls_start`/`upd_start`, single write 0x20 data 0x100, `interupt`.
- `go` pulsed during CLS_WAIT; stray `upd_done` during CLS_WAIT → no restart, no state change, counts unaffected.
- `rst` asserted in UPD_WAIT → all outputs 0 next cycle. A new `go` afterwards starts at `cls_point_addr`=0 with `iter_cnt`=0.
- `cls_done` delayed 5 cycles with `cls_changed` only on the last point of pass 1 → pass 2 runs (no early convergence), and `busy` stays high throughout.

Source files
------------

// File: rtl/k_means_pkg.sv
// k-means iteration scheduler: shared state encoding, register map and status-word layout.
// Latency: n/a (constants, types and one pure function).
// Backpressure: n/a.
package k_means_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLS_ISSUE,
        CLS_WAIT,
        UPD_ISSUE,
        UPD_WAIT,
        WB_CENT,
        WB_STAT,
        DONE
    } sched_state_t;

    // Register-file map
    localparam logic [7:0] CENT_BASE  = 8'h10;
    localparam logic [7:0] STATUS_REG = 8'h20;

    // Largest supported cluster count; sets the writeback index width
    localparam int MAX_K = 8;

    // Status word layout: {converged, iter_cnt[7:0]}, zero-extended to the data width
    localparam int STAT_ITER_LSB = 0;
    localparam int STAT_ITER_W   = 8;
    localparam int STAT_CONV_BIT = 8;
    localparam int STAT_W        = 9;

    function automatic logic [STAT_W-1:0] stat_word(input logic conv, input logic [7:0] iter);
        logic [STAT_W-1:0] w;
        w                                   = '0;
        w[STAT_CONV_BIT]                    = conv;
        w[STAT_ITER_LSB +: STAT_ITER_W]     = iter;
        return w;
    endfunction

endpackage

// File: rtl/k_means_sched.sv
// k-means iteration scheduler: classify all points, update centroids, repeat until stable or M iterations, then write back.
// Latency: go -> cls_start next cycle; last cls_done -> upd_start or first writeback next cycle; status write -> interupt next cycle.
// Backpressure: one point in flight, each step blocks until cls_done / upd_done; writeback is unthrottled (k + 1 consecutive writes).
module k_means_sched #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 91
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [addrWidth-1:0] num_points,
    input  logic [2:0]           centroid_cnt,
    input  logic [7:0]           max_iter,
    output logic                 cls_start,
    output logic [addrWidth-1:0] cls_point_addr,
    input  logic                 cls_done,
    input  logic                 cls_changed,
    output logic                 upd_start,
    input  logic                 upd_done,
    output logic [2:0]           cen_idx,
    input  logic [dataWidth-1:0] cen_data,
    output logic [addrWidth-1:0] reg_num,
    output logic                 reg_w_r,
    output logic [dataWidth-1:0] reg_write_data,
    output logic                 busy,
    output logic                 interupt
);
    import k_means_pkg::*;

    localparam int IDX_W = $clog2(MAX_K);

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    sched_state_t         state_q, state_d;
    logic [addrWidth-1:0] pt_cnt_q, pt_cnt_d;
    logic [7:0]           iter_cnt_q, iter_cnt_d;
    logic                 changed_any_q, changed_any_d;
    logic                 converged_q, converged_d;
    logic [IDX_W-1:0]     wb_idx_q, wb_idx_d;

    // Job parameters captured on an accepted go
    logic [addrWidth-1:0] n_lat_q, n_lat_d;
    logic [2:0]           k_lat_q, k_lat_d;
    logic [7:0]           m_lat_q, m_lat_d;

    // Next values of the registered outputs
    logic                 cls_start_d;
    logic [addrWidth-1:0] cls_point_addr_d;
    logic                 upd_start_d;
    logic [2:0]           cen_idx_d;
    logic [addrWidth-1:0] reg_num_d;
    logic                 reg_w_r_d;
    logic [dataWidth-1:0] wdata_q, wdata_d;
    logic                 busy_d;
    logic                 interupt_d;

    // Helpers for the end-of-pass / end-of-update decisions
    logic                 enter_wb;
    logic                 last_pt;
    logic                 pass_changed;
    logic [7:0]           iter_inc;

    assign last_pt  = (pt_cnt_q == (n_lat_q - addrWidth'(1)));
    assign iter_inc = (iter_cnt_q == 8'hFF) ? iter_cnt_q : (iter_cnt_q + 8'd1);

    // Centroid writes forward cen_data in the same cycle cen_idx selects it; the status write is registered
    assign reg_write_data = (state_q == WB_CENT) ? cen_data : wdata_q;

    // Next-state, counter and output decode; every register's next value defaults to hold or idle first
    always_comb begin
        state_d          = state_q;
        pt_cnt_d         = pt_cnt_q;
        iter_cnt_d       = iter_cnt_q;
        changed_any_d    = changed_any_q;
        converged_d      = converged_q;
        wb_idx_d         = wb_idx_q;
        n_lat_d          = n_lat_q;
        k_lat_d          = k_lat_q;
        m_lat_d          = m_lat_q;
        cls_start_d      = 1'b0;
        cls_point_addr_d = cls_point_addr;
        upd_start_d      = 1'b0;
        cen_idx_d        = '0;
        reg_num_d        = '0;
        reg_w_r_d        = 1'b0;
        wdata_d          = '0;
        interupt_d       = interupt;
        enter_wb         = 1'b0;
        pass_changed     = changed_any_q | cls_changed;

        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    n_lat_d       = num_points;
                    k_lat_d       = centroid_cnt;
                    m_lat_d       = (max_iter == 8'd0) ? 8'd1 : max_iter;
                    pt_cnt_d      = '0;
                    iter_cnt_d    = '0;
                    changed_any_d = 1'b0;
                    interupt_d    = 1'b0;
                    if (num_points == '0) begin
                        // Nothing to cluster: report converged with zero iterations
                        converged_d = 1'b1;
                        state_d     = WB_STAT;
                        reg_w_r_d   = 1'b1;
                        reg_num_d   = addrWidth'(STATUS_REG);
                        wdata_d     = dataWidth'(stat_word(1'b1, 8'd0));
                    end else begin
                        state_d          = CLS_ISSUE;
                        cls_start_d      = 1'b1;
                        cls_point_addr_d = '0;
                    end
                end
            end

            CLS_ISSUE: begin
                state_d = CLS_WAIT;
            end

            CLS_WAIT: begin
                if (cls_done) begin
                    changed_any_d = pass_changed;
                    if (!last_pt) begin
                        pt_cnt_d         = pt_cnt_q + addrWidth'(1);
                        state_d          = CLS_ISSUE;
                        cls_start_d      = 1'b1;
                        cls_point_addr_d = pt_cnt_q + addrWidth'(1);
                    end else if ((iter_cnt_q != 8'd0) && !pass_changed) begin
                        // A full pass after at least one update moved nothing
                        converged_d = 1'b1;
                        enter_wb    = 1'b1;
                    end else begin
                        state_d     = UPD_ISSUE;
                        upd_start_d = 1'b1;
                    end
                end
            end

            UPD_ISSUE: begin
                state_d = UPD_WAIT;
            end

            UPD_WAIT: begin
                if (upd_done) begin
                    iter_cnt_d = iter_inc;
                    if (iter_inc == m_lat_q) begin
                        converged_d = 1'b0;
                        enter_wb    = 1'b1;
                    end else begin
                        pt_cnt_d         = '0;
                        changed_any_d    = 1'b0;
                        state_d          = CLS_ISSUE;
                        cls_start_d      = 1'b1;
                        cls_point_addr_d = '0;
                    end
                end
            end

            WB_CENT: begin
                if (wb_idx_q == k_lat_q) begin
                    state_d   = WB_STAT;
                    reg_w_r_d = 1'b1;
                    reg_num_d = addrWidth'(STATUS_REG);
                    wdata_d   = dataWidth'(stat_word(converged_q, iter_cnt_q));
                end else begin
                    wb_idx_d  = wb_idx_q + IDX_W'(1);
                    cen_idx_d = wb_idx_q + IDX_W'(1);
                    reg_w_r_d = 1'b1;
                    reg_num_d = addrWidth'(CENT_BASE) + addrWidth'(wb_idx_q + IDX_W'(1));
                end
            end

            WB_STAT: begin
                state_d    = DONE;
                interupt_d = 1'b1;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Common entry into centroid writeback: first write goes out in the next cycle
        if (enter_wb) begin
            state_d   = WB_CENT;
            wb_idx_d  = '0;
            cen_idx_d = '0;
            reg_w_r_d = 1'b1;
            reg_num_d = addrWidth'(CENT_BASE);
        end

        busy_d = !((state_d == IDLE) || (state_d == DONE));
    end

    // State, counters and registered outputs; reset aborts any job and drops pending pulses/writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pt_cnt_q       <= '0;
            iter_cnt_q     <= '0;
            changed_any_q  <= 1'b0;
            converged_q    <= 1'b0;
            wb_idx_q       <= '0;
            n_lat_q        <= '0;
            k_lat_q        <= '0;
            m_lat_q        <= '0;
            cls_start      <= 1'b0;
            cls_point_addr <= '0;
            upd_start      <= 1'b0;
            cen_idx        <= '0;
            reg_num        <= '0;
            reg_w_r        <= 1'b0;
            wdata_q        <= '0;
            busy           <= 1'b0;
            interupt       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pt_cnt_q       <= pt_cnt_d;
            iter_cnt_q     <= iter_cnt_d;
            changed_any_q  <= changed_any_d;
            converged_q    <= converged_d;
            wb_idx_q       <= wb_idx_d;
            n_lat_q        <= n_lat_d;
            k_lat_q        <= k_lat_d;
            m_lat_q        <= m_lat_d;
            cls_start      <= cls_start_d;
            cls_point_addr <= cls_point_addr_d;
            upd_start      <= upd_start_d;
            cen_idx        <= cen_idx_d;
            reg_num        <= reg_num_d;
            reg_w_r        <= reg_w_r_d;
            wdata_q        <= wdata_d;
            busy           <= busy_d;
            interupt       <= interupt_d;
        end
    end

endmodule

// File: tb/tb_k_means_sched.sv
// Directed bench for k_means_sched: scripted classify/update responders, write monitor, per-scenario checks.
// Latency: n/a.
// Backpressure: responders hold cls_done / upd_done off for a programmable number of cycles.
`timescale 1ns/1ps
module tb_k_means_sched;
    localparam int AW = 8;
    localparam int DW = 91;
    localparam logic [DW-1:0] CEN_TAG = {8'hA5, 83'h0};

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic [AW-1:0] num_points;
    logic [2:0]    centroid_cnt;
    logic [7:0]    max_iter;
    logic          cls_start;
    logic [AW-1:0] cls_point_addr;
    logic          cls_done;
    logic          cls_changed;
    logic          upd_start;
    logic          upd_done;
    logic          upd_done_resp;
    logic          upd_done_stray;
    logic [2:0]    cen_idx;
    logic [DW-1:0] cen_data;
    logic [AW-1:0] reg_num;
    logic          reg_w_r;
    logic [DW-1:0] reg_write_data;
    logic          busy;
    logic          interupt;

    assign upd_done = upd_done_resp | upd_done_stray;
    assign cen_data = CEN_TAG | DW'(cen_idx);

    k_means_sched #(.addrWidth(AW), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .go(go), .num_points(num_points),
        .centroid_cnt(centroid_cnt), .max_iter(max_iter),
        .cls_start(cls_start), .cls_point_addr(cls_point_addr),
        .cls_done(cls_done), .cls_changed(cls_changed),
        .upd_start(upd_start), .upd_done(upd_done),
        .cen_idx(cen_idx), .cen_data(cen_data),
        .reg_num(reg_num), .reg_w_r(reg_w_r), .reg_write_data(reg_write_data),
        .busy(busy), .interupt(interupt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Responder configuration, written only by the main sequence
    int mode      = 1;
    int cls_delay = 1;
    int upd_delay = 1;
    int cur_n     = 0;
    int pass_base = 0;

    // Monitor record, written only by the monitor
    int              cyc       = 0;
    int              upd_cnt   = 0;
    int              intr_cyc  = -1;
    logic            intr_prev = 1'b0;
    int              cls_addr_q[$];
    logic [AW-1:0]   wr_num_q[$];
    logic [DW-1:0]   wr_dat_q[$];
    int              wr_cyc_q[$];

    function automatic logic want_changed(input int m, input int pass, input int addr, input int n);
        case (m)
            0:       return (pass < 2);
            1:       return 1'b1;
            2:       return (pass == 1) && (addr == n - 1);
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: sample DUT outputs mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cls_start) cls_addr_q.push_back(int'(cls_point_addr));
        if (upd_start) upd_cnt = upd_cnt + 1;
        if (reg_w_r) begin
            wr_num_q.push_back(reg_num);
            wr_dat_q.push_back(reg_write_data);
            wr_cyc_q.push_back(cyc);
        end
        if (interupt && !intr_prev) intr_cyc = cyc;
        intr_prev = interupt;
    end

    // Datapath stand-in: answers each cls_start / upd_start after the configured delay
    initial begin : responder
        int a;
        cls_done      = 1'b0;
        cls_changed   = 1'b0;
        upd_done_resp = 1'b0;
        forever begin
            @(negedge clk);
            cls_done      = 1'b0;
            cls_changed   = 1'b0;
            upd_done_resp = 1'b0;
            if (!rst && cls_start) begin
                a = int'(cls_point_addr);
                repeat (cls_delay) @(negedge clk);
                cls_done    = !rst;
                cls_changed = want_changed(mode, upd_cnt - pass_base, a, cur_n);
            end else if (!rst && upd_start) begin
                repeat (upd_delay) @(negedge clk);
                upd_done_resp = !rst;
            end
        end
    end

    task automatic do_go(input logic [7:0] n, input logic [2:0] k, input logic [7:0] m);
        @(negedge clk);
        num_points   = n;
        centroid_cnt = k;
        max_iter     = m;
        go           = 1'b1;
        @(negedge clk);
        go           = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out, output int gaps);
        timed_out = 1'b1;
        gaps      = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (interupt) begin
                timed_out = 1'b0;
                break;
            end
            if (!busy) gaps++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; num_points = '0; centroid_cnt = '0; max_iter = '0;
        upd_done_stray = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, interupt, cls_start, upd_start, reg_w_r} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000", {busy, interupt, cls_start, upd_start, reg_w_r});
        end
        tests_run++;
        if ({cls_point_addr, cen_idx, reg_num} !== 19'h0) begin
            fails++; $display("FAIL reset_addrs: got addr=%0h idx=%0d num=%0h expected 0", cls_point_addr, cen_idx, reg_num);
        end
        tests_run++;
        if (reg_write_data !== '0) begin
            fails++; $display("FAIL reset_wdata: got %h expected 0", reg_write_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_converge();
        int cb, ub, wb, gaps; bit to, ok;
        mode = 0; cls_delay = 1; upd_delay = 1; cur_n = 4;
        cb = cls_addr_q.size(); ub = upd_cnt; wb = wr_num_q.size(); pass_base = upd_cnt;
        do_go(8'd4, 3'd2, 8'd10);
        tests_run++;
        if ({cls_start, busy, cls_point_addr} !== {1'b1, 1'b1, 8'd0}) begin
            fails++; $display("FAIL conv_first_issue: got start=%b busy=%b addr=%0d expected 1 1 0", cls_start, busy, cls_point_addr);
        end
        wait_done(2000, to, gaps);
        tests_run++;
        if (to) begin fails++; $display("FAIL conv_timeout: no interupt within budget"); end
        tests_run++;
        if (cls_addr_q.size() - cb != 12) begin
            fails++; $display("FAIL conv_cls_count: got %0d expected 12", cls_addr_q.size() - cb);
        end
        ok = 1'b1;
        for (int i = 0; i < 12; i++) if (cls_addr_q[cb + i] != (i % 4)) ok = 1'b0;
        tests_run++;
        if (!ok) begin fails++; $display("FAIL conv_addr_seq: got non 0..3 sequence expected 0,1,2,3 x3"); end
        tests_run++;
        if (upd_cnt - ub != 2) begin fails++; $display("FAIL conv_upd_count: got %0d expected 2", upd_cnt - ub); end
        tests_run++;
        if (wr_num_q.size() - wb != 4) begin fails++; $display("FAIL conv_wr_count: got %0d expected 4", wr_num_q.size() - wb); end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (wr_num_q[wb + i] !== AW'(8'h10 + i) || wr_dat_q[wb + i] !== (CEN_TAG | DW'(i))) begin
                fails++; $display("FAIL conv_cent_wr%0d: got num=%0h data=%h expected num=%0h data=%h",
                                  i, wr_num_q[wb + i], wr_dat_q[wb + i], 8'h10 + i, CEN_TAG | DW'(i));
            end
        end
        tests_run++;
        if (wr_num_q[wb + 3] !== 8'h20 || wr_dat_q[wb + 3] !== DW'(12'h102)) begin
            fails++; $display("FAIL conv_status: got num=%0h data=%h expected 20 / 102", wr_num_q[wb + 3], wr_dat_q[wb + 3]);
        end
        tests_run++;
        if (wr_cyc_q[wb + 3] - wr_cyc_q[wb] != 3 || intr_cyc != wr_cyc_q[wb + 3] + 1) begin
            fails++; $display("FAIL conv_wb_timing: got span=%0d intr_gap=%0d expected 3 / 1",
                              wr_cyc_q[wb + 3] - wr_cyc_q[wb], intr_cyc - wr_cyc_q[wb + 3]);
        end
        tests_run++;
        if ({interupt, busy} !== 2'b10) begin fails++; $display("FAIL conv_done_flags: got intr=%b busy=%b expected 1 0", interupt, busy); end
    endtask

    task automatic test_iter_limit();
        int cb, ub, wb, gaps; bit to;
        mode = 1; cls_delay = 1; upd_delay = 2; cur_n = 2;
        cb = cls_addr_q.size(); ub = upd_cnt; wb = wr_num_q.size(); pass_base = upd_cnt;
        do_go(8'd2, 3'd0, 8'd3);
        tests_run++;
        if (interupt !== 1'b0) begin fails++; $display("FAIL lim_intr_clear: got %b expected 0", interupt); end
        wait_done(2000, to, gaps);
        tests_run++;
        if (to) begin fails++; $display("FAIL lim_timeout: no interupt within budget"); end
        tests_run++;
        if (upd_cnt - ub != 3 || cls_addr_q.size() - cb != 6) begin
            fails++; $display("FAIL lim_counts: got upd=%0d cls=%0d expected 3 / 6", upd_cnt - ub, cls_addr_q.size() - cb);
        end
        tests_run++;
        if (wr_num_q.size() - wb != 2 || wr_num_q[wb] !== 8'h10 || wr_dat_q[wb] !== CEN_TAG) begin
            fails++; $display("FAIL lim_cent_wr: got n=%0d num=%0h data=%h expected 2 / 10 / %h",
                              wr_num_q.size() - wb, wr_num_q[wb], wr_dat_q[wb], CEN_TAG);
        end
        tests_run++;
        if (wr_num_q[wb + 1] !== 8'h20 || wr_dat_q[wb + 1] !== DW'(12'h003)) begin
            fails++; $display("FAIL lim_status: got num=%0h data=%h expected 20 / 003", wr_num_q[wb + 1], wr_dat_q[wb + 1]);
        end
    endtask

    task automatic test_zero_points();
        int cb, ub, wb, gaps; bit to;
        cb = cls_addr_q.size(); ub = upd_cnt; wb = wr_num_q.size(); pass_base = upd_cnt;
        do_go(8'd0, 3'd3, 8'd5);
        wait_done(100, to, gaps);
        tests_run++;
        if (to) begin fails++; $display("FAIL zero_timeout: no interupt within budget"); end
        tests_run++;
        if (cls_addr_q.size() != cb || upd_cnt != ub) begin
            fails++; $display("FAIL zero_no_work: got cls=%0d upd=%0d expected 0 / 0", cls_addr_q.size() - cb, upd_cnt - ub);
        end
        tests_run++;
        if (wr_num_q.size() - wb != 1 || wr_num_q[wb] !== 8'h20 || wr_dat_q[wb] !== DW'(12'h100)) begin
            fails++; $display("FAIL zero_status: got n=%0d num=%0h data=%h expected 1 / 20 / 100",
                              wr_num_q.size() - wb, wr_num_q[wb], wr_dat_q[wb]);
        end
    endtask

    task automatic test_ignored_inputs();
        int cb, ub, wb, gaps; bit to, ok;
        mode = 1; cls_delay = 4; upd_delay = 1; cur_n = 3;
        cb = cls_addr_q.size(); ub = upd_cnt; wb = wr_num_q.size(); pass_base = upd_cnt;
        do_go(8'd3, 3'd1, 8'd2);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        upd_done_stray = 1'b1;
        tests_run++;
        if ({cls_start, busy} !== 2'b01) begin
            fails++; $display("FAIL ign_go_restart: got start=%b busy=%b expected 0 1", cls_start, busy);
        end
        @(negedge clk);
        upd_done_stray = 1'b0;
        tests_run++;
        if (upd_start !== 1'b0) begin fails++; $display("FAIL ign_stray_upd: got upd_start=%b expected 0", upd_start); end
        wait_done(2000, to, gaps);
        tests_run++;
        if (to) begin fails++; $display("FAIL ign_timeout: no interupt within budget"); end
        ok = (cls_addr_q.size() - cb == 6);
        for (int i = 0; i < 6; i++) if (cls_addr_q[cb + i] != (i % 3)) ok = 1'b0;
        tests_run++;
        if (!ok) begin fails++; $display("FAIL ign_addr_seq: got %0d issues expected 6 as 0,1,2,0,1,2", cls_addr_q.size() - cb); end
        tests_run++;
        if (upd_cnt - ub != 2 || wr_num_q.size() - wb != 3 || wr_dat_q[wb + 2] !== DW'(12'h002)) begin
            fails++; $display("FAIL ign_result: got upd=%0d wr=%0d status=%h expected 2 / 3 / 002",
                              upd_cnt - ub, wr_num_q.size() - wb, wr_dat_q[wb + 2]);
        end
    endtask

    task automatic test_reset_mid();
        int wb, gaps, n; bit to, seen;
        mode = 1; cls_delay = 1; upd_delay = 6; cur_n = 3; pass_base = upd_cnt;
        do_go(8'd3, 3'd1, 8'd5);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (upd_start) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin fails++; $display("FAIL rstmid_no_upd: upd_start not seen within budget"); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({busy, interupt, cls_start, upd_start, reg_w_r, cls_point_addr, cen_idx, reg_num} !== '0 || reg_write_data !== '0) begin
            fails++; $display("FAIL rstmid_outputs: got busy=%b addr=%0h num=%0h wdata=%h expected all 0",
                              busy, cls_point_addr, reg_num, reg_write_data);
        end
        repeat (10) @(negedge clk);
        rst = 1'b0;
        upd_delay = 1; cur_n = 2; pass_base = upd_cnt;
        n  = cls_addr_q.size();
        wb = wr_num_q.size();
        do_go(8'd2, 3'd0, 8'd1);
        tests_run++;
        if ({cls_start, cls_point_addr} !== {1'b1, 8'd0}) begin
            fails++; $display("FAIL rstmid_restart: got start=%b addr=%0d expected 1 0", cls_start, cls_point_addr);
        end
        wait_done(2000, to, gaps);
        tests_run++;
        if (to || cls_addr_q.size() - n != 2 || wr_dat_q[wb + 1] !== DW'(12'h001)) begin
            fails++; $display("FAIL rstmid_iter: got timeout=%b cls=%0d status=%h expected 0 / 2 / 001",
                              to, cls_addr_q.size() - n, wr_dat_q[wb + 1]);
        end
    endtask

    task automatic test_slow_done();
        int cb, ub, wb, gaps; bit to;
        mode = 2; cls_delay = 5; upd_delay = 3; cur_n = 3;
        cb = cls_addr_q.size(); ub = upd_cnt; wb = wr_num_q.size(); pass_base = upd_cnt;
        do_go(8'd3, 3'd1, 8'd10);
        wait_done(3000, to, gaps);
        tests_run++;
        if (to) begin fails++; $display("FAIL slow_timeout: no interupt within budget"); end
        tests_run++;
        if (gaps != 0) begin fails++; $display("FAIL slow_busy: got %0d low cycles expected 0", gaps); end
        tests_run++;
        if (cls_addr_q.size() - cb != 9 || upd_cnt - ub != 2) begin
            fails++; $display("FAIL slow_counts: got cls=%0d upd=%0d expected 9 / 2", cls_addr_q.size() - cb, upd_cnt - ub);
        end
        tests_run++;
        if (wr_num_q.size() - wb != 3 || wr_num_q[wb + 1] !== 8'h11 || wr_dat_q[wb + 1] !== (CEN_TAG | DW'(1))
            || wr_dat_q[wb + 2] !== DW'(12'h102)) begin
            fails++; $display("FAIL slow_writes: got n=%0d num1=%0h status=%h expected 3 / 11 / 102",
                              wr_num_q.size() - wb, wr_num_q[wb + 1], wr_dat_q[wb + 2]);
        end
    endtask

    initial begin
        test_reset();
        test_converge();
        test_iter_limit();
        test_zero_points();
        test_ignored_inputs();
        test_reset_mid();
        test_slow_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
